// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder: {co,s} = a + b + ci, CHUNK bits per clock with the
// inter-chunk carry held in a register. Operands are taken through a start/busy/done handshake.
module rca_seq_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    int unsigned      base;
    logic [CHUNK:0]   chunk_sum;

    // One CHUNK-wide slice of the add; the top bit is the carry into the next slice.
    always_comb begin
        base      = 32'(cnt_q) * CHUNK;
        chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                  + (CHUNK + 1)'(carry_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s       <= '0;
            co      <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ci;
                        cnt_q   <= '0;
                        s       <= '0;
                        co      <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    s[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry_q          <= chunk_sum[CHUNK];
                    if (cnt_q == LAST) begin
                        co      <= chunk_sum[CHUNK];
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_adder.sv
// Scoreboard bench for rca_seq_adder: three instances (16/4, 4/1, 8/8) share one clock;
// a bench-side handshake model queues expected sums at each accepting edge.
module tb_rca_seq_adder;

    logic        clk;
    logic        rst0, start0, ci0, busy0, done0, co0;
    logic [15:0] a0, b0, s0;
    logic        rst1, start1, ci1, busy1, done1, co1;
    logic [3:0]  a1, b1, s1;
    logic        rst2, start2, ci2, busy2, done2, co2;
    logic [7:0]  a2, b2, s2;

    rca_seq_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .a(a0), .b(b0), .ci(ci0),
        .busy(busy0), .done(done0), .s(s0), .co(co0)
    );
    rca_seq_adder #(.WIDTH(4), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .ci(ci1),
        .busy(busy1), .done(done1), .s(s1), .co(co1)
    );
    rca_seq_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .ci(ci2),
        .busy(busy2), .done(done2), .s(s2), .co(co2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          nc    [3];
    int          left  [3];
    logic [16:0] last  [3];
    logic [16:0] exp_q [3][$];
    int          acc_q [3][$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        left[d] = 0;
        last[d] = '0;
        exp_q[d].delete();
        acc_q[d].delete();
    endtask

    // Accepting edge: IDLE with start high; afterwards NCH RUN edges plus one DONE edge.
    task automatic model_edge(input int d, input logic st, input logic [16:0] e, input int nch);
        if (left[d] == 0) begin
            if (st) begin
                exp_q[d].push_back(e);
                acc_q[d].push_back(nc[d]);
                left[d] = nch + 1;
            end
        end else begin
            left[d] = left[d] - 1;
        end
    endtask

    task automatic mon(input int d, input logic dn, input logic bz, input logic [16:0] got,
                       input int nch);
        logic [16:0] e;
        int          acc;
        nc[d] = nc[d] + 1;
        if (dn) begin
            if (exp_q[d].size() == 0) begin
                check_eq($sformatf("dut%0d_spurious_done", d), 32'd1, 32'd0);
            end else begin
                e   = exp_q[d].pop_front();
                acc = acc_q[d].pop_front();
                check_eq($sformatf("dut%0d_sum", d), 32'(got), 32'(e));
                // Accept is recorded between negedges, so done is seen NCH+1 negedges later.
                check_eq($sformatf("dut%0d_latency", d), 32'(nc[d] - acc), 32'(nch + 1));
                last[d] = e;
            end
        end else if (!bz) begin
            check_eq($sformatf("dut%0d_hold", d), 32'(got), 32'(last[d]));
        end
    endtask

    always @(posedge clk or posedge rst0)
        if (rst0) model_reset(0);
        else model_edge(0, start0, 17'(a0) + 17'(b0) + 17'(ci0), 4);
    always @(posedge clk or posedge rst1)
        if (rst1) model_reset(1);
        else model_edge(1, start1, 17'(a1) + 17'(b1) + 17'(ci1), 4);
    always @(posedge clk or posedge rst2)
        if (rst2) model_reset(2);
        else model_edge(2, start2, 17'(a2) + 17'(b2) + 17'(ci2), 1);

    always @(negedge clk) begin
        mon(0, done0, busy0, 17'({co0, s0}), 4);
        mon(1, done1, busy1, 17'({co1, s1}), 4);
        mon(2, done2, busy2, 17'({co2, s2}), 1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        for (int d = 0; d < 3; d++) begin
            nc[d] = 0;
            model_reset(d);
        end
        {start0, ci0, a0, b0} = '0;
        {start1, ci1, a1, b1} = '0;
        {start2, ci2, a2, b2} = '0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        #12;
        check_eq("reset_busy", 32'(busy0), 32'd0);
        check_eq("reset_done", 32'(done0), 32'd0);
        check_eq("reset_sum", 32'({co0, s0}), 32'd0);
        check_eq("reset_sum_w4", 32'({co1, s1, busy1}), 32'd0);
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // 0xFFFF + 1: full carry ripple, busy for NCH+1 cycles
        @(negedge clk);
        a0 = 16'hFFFF; b0 = 16'h0001; ci0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; a0 = 16'h0000; b0 = 16'h0000;
        bc = 0;
        repeat (8) begin
            bc += int'(busy0);
            if (done0) begin
                check_eq("t1_s", 32'(s0), 32'h0000);
                check_eq("t1_co", 32'(co0), 32'd1);
            end
            @(negedge clk);
        end
        check_eq("t1_busy_cycles", 32'(bc), 32'd5);

        // start during RUN must be ignored
        a0 = 16'h1234; b0 = 16'h4321; ci0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; a0 = 16'hAAAA; ci0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1; a0 = 16'hFFFF; b0 = 16'hFFFF;
        @(negedge clk);
        start0 = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t2_s", 32'(s0), 32'h5556);
        check_eq("t2_co", 32'(co0), 32'd0);

        // reset after the second RUN edge aborts the add
        a0 = 16'h7777; b0 = 16'h8888; ci0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst0 = 1'b1;
        #1;
        check_eq("t5_s_rst", 32'(s0), 32'd0);
        check_eq("t5_co_rst", 32'(co0), 32'd0);
        check_eq("t5_busy_rst", 32'(busy0), 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        a0 = 16'h0F0F; b0 = 16'h00F1; ci0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t5_s", 32'(s0), 32'h1000);
        check_eq("t5_co", 32'(co0), 32'd0);

        // back-to-back with start held and operands changing every cycle
        repeat (60) begin
            a0 = 16'($urandom); b0 = 16'($urandom); ci0 = 1'($urandom); start0 = 1'b1;
            @(negedge clk);
        end
        start0 = 1'b0;
        repeat (8) @(negedge clk);

        // single-pass 8-bit instance
        a2 = 8'h80; b2 = 8'h80; ci2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; a2 = 8'h00; b2 = 8'h00;
        @(negedge clk);
        check_eq("t4_done", 32'(done2), 32'd1);
        check_eq("t4_s", 32'(s2), 32'h00);
        check_eq("t4_co", 32'(co2), 32'd1);
        @(negedge clk);
        repeat (10) begin
            a2 = 8'($urandom); b2 = 8'($urandom); ci2 = 1'($urandom); start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0; a2 = ~a2;
            repeat (2) @(negedge clk);
        end

        // exhaustive bit-serial sweep
        for (int i = 0; i < 512; i++) begin
            a1 = 4'(i >> 5); b1 = 4'(i >> 1); ci1 = 1'(i); start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom); ci1 = 1'($urandom);
            repeat (5) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++)
            check_eq($sformatf("dut%0d_pending", d), 32'(exp_q[d].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
